cdb_arbiter: RTL and testbench

- Round-robin scheduler for the common data bus (CDB) that feeds the ROB write-back port and the reservation-station wakeup logic.
- Each functional-unit requester (ALU, multiplier, load buffer, branch unit) hands over one result through a valid/ready handshake into a private one-entry holding slot.
- The arbiter grants at most one full slot per cycle and drives a registered CDB beat: `cdb_valid`, ROB index, value and destination.
- Sits between the execution units and the `rob`'s `cdb_*_in` ports.

---
 rtl/cdb_arbiter_pkg.sv | 19 +
 rtl/cdb_arbiter_rr_picker.sv | 28 ++
 rtl/cdb_arbiter.sv | 121 ++++++++++++
 tb/tb_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter constants: requester indices, default sizes and the result message layout.
package cdb_arbiter_pkg;

    localparam int CDB_NUM_REQ  = 4;
    localparam int CDB_ROB_SIZE = 8;
    localparam int CDB_PTR_SIZE = $clog2(CDB_ROB_SIZE);

    localparam int CDB_ALU    = 0;
    localparam int CDB_MUL    = 1;
    localparam int CDB_LOAD   = 2;
    localparam int CDB_BRANCH = 3;

    typedef struct packed {
        logic [CDB_PTR_SIZE-1:0] rob_ix;
        logic signed [31:0]      value;
        logic signed [31:0]      dest;
    } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot select of the first set request at or after ptr.
module rr_picker #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] sel
);

    logic [W-1:0] idx;
    logic         found;

    // Wrap by compare so that N need not be a power of two.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                sel[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = (idx == W'(N - 1)) ? '0 : idx + W'(1);
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-entry holding slot per functional unit, one registered beat per cycle.
// Define CDB_ARB_STATS_EN to add per-requester grant counters and a contention counter.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = CDB_NUM_REQ,
    parameter int ROB_SIZE = CDB_ROB_SIZE,
    localparam int PTR_SIZE = $clog2(ROB_SIZE),
    localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               flush_in,
    input  logic [NUM_REQ-1:0]                 req_valid_in,
    input  logic [NUM_REQ-1:0][PTR_SIZE-1:0]   req_rob_ix_in,
    input  logic [NUM_REQ-1:0][31:0]           req_value_in,
    input  logic [NUM_REQ-1:0][31:0]           req_dest_in,
    output logic [NUM_REQ-1:0]                 req_ready_out,
    output logic                               cdb_valid_out,
    output logic [PTR_SIZE-1:0]                cdb_rob_ix_out,
    output logic signed [31:0]                 cdb_value_out,
    output logic signed [31:0]                 cdb_dest_out,
    output logic [NUM_REQ-1:0]                 grant_out
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]           grant_count_out,
    output logic [31:0]                        conflict_count_out
`endif
);

    typedef struct packed {
        logic [PTR_SIZE-1:0] rob_ix;
        logic [31:0]         value;
        logic [31:0]         dest;
    } msg_t;

    msg_t [NUM_REQ-1:0] slot;
    logic [NUM_REQ-1:0] full;
    logic [NUM_REQ-1:0] sel;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      sel_ix;
    msg_t               sel_msg;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req (full),
        .ptr (rr_ptr),
        .sel (sel)
    );

    always_comb begin
        sel_ix  = '0;
        sel_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel[i]) begin
                sel_ix  = IW'(i);
                sel_msg = slot[i];
            end
        end
    end

    // A slot being granted this cycle may refill at the same edge.
    assign req_ready_out = flush_in ? '0 : (~full | sel);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            full <= '0;
            slot <= '0;
        end else if (flush_in) begin
            full <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid_in[i] && req_ready_out[i]) begin
                    full[i] <= 1'b1;
                    slot[i] <= '{rob_ix: req_rob_ix_in[i],
                                 value:  req_value_in[i],
                                 dest:   req_dest_in[i]};
                end else if (sel[i]) begin
                    full[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cdb_valid_out  <= 1'b0;
            grant_out      <= '0;
            cdb_rob_ix_out <= '0;
            cdb_value_out  <= '0;
            cdb_dest_out   <= '0;
            rr_ptr         <= '0;
        end else if (flush_in) begin
            cdb_valid_out <= 1'b0;
            grant_out     <= '0;
        end else begin
            cdb_valid_out <= |sel;
            grant_out     <= sel;
            if (|sel) begin
                cdb_rob_ix_out <= sel_msg.rob_ix;
                cdb_value_out  <= sel_msg.value;
                cdb_dest_out   <= sel_msg.dest;
                rr_ptr         <= (sel_ix == IW'(NUM_REQ - 1)) ? '0 : sel_ix + IW'(1);
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            grant_count_out    <= '0;
            conflict_count_out <= '0;
        end else if (!flush_in) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (sel[i]) grant_count_out[i] <= grant_count_out[i] + 32'd1;
            if ($countones(full) > 1)
                conflict_count_out <= conflict_count_out + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: cycle table for contention/streaming plus hand sequences.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst_in;
    logic             flush_in;
    logic [3:0]       vld;
    logic [3:0][2:0]  rix;
    logic [3:0][31:0] rval;
    logic [3:0][31:0] rdst;
    logic [3:0]       ready;
    logic             cdb_valid;
    logic [2:0]       cdb_ix;
    logic [31:0]      cdb_value;
    logic [31:0]      cdb_dest;
    logic [3:0]       grant;
`ifdef CDB_ARB_STATS_EN
    logic [3:0][31:0] gcnt;
    logic [31:0]      ccnt;
`endif

    cdb_arbiter dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .flush_in       (flush_in),
        .req_valid_in   (vld),
        .req_rob_ix_in  (rix),
        .req_value_in   (rval),
        .req_dest_in    (rdst),
        .req_ready_out  (ready),
        .cdb_valid_out  (cdb_valid),
        .cdb_rob_ix_out (cdb_ix),
        .cdb_value_out  (cdb_value),
        .cdb_dest_out   (cdb_dest),
        .grant_out      (grant)
`ifdef CDB_ARB_STATS_EN
        ,
        .grant_count_out    (gcnt),
        .conflict_count_out (ccnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        cdb_msg_t   msg;
    } beat_t;

    typedef struct {
        logic [3:0] vld;
        int         val;
        logic [3:0] rdy;
        int         src;
        int         bval;
    } vec_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester i gets ix=i, value=1000*i+base, dest=~value.
    task automatic drive_all(input logic [3:0] v, input int base);
        for (int i = 0; i < 4; i++) begin
            rix[i]  = 3'(i);
            rval[i] = 32'(1000 * i + base);
            rdst[i] = ~rval[i];
        end
        vld = v;
    endtask

    task automatic push_beat(input int src, input int val);
        beat_t b;
        b.grant      = 4'b0001 << src;
        b.msg.rob_ix = 3'(src);
        b.msg.value  = 32'(val);
        b.msg.dest   = ~(32'(val));
        exp_q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst_in) begin
            if (cdb_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_beat: got grant=%b ix=%0d value=%0d, expected no beat",
                             grant, cdb_ix, cdb_value);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_grant", 32'(grant), 32'(e.grant));
                    chk("beat_ix", 32'(cdb_ix), 32'(e.msg.rob_ix));
                    chk("beat_value", cdb_value, e.msg.value);
                    chk("beat_dest", cdb_dest, e.msg.dest);
                end
            end else begin
                chk("idle_grant", 32'(grant), 32'd0);
            end
        end
    end

    vec_t tbl[21];

    initial begin
        // Rows: inputs this cycle, ready expected this cycle, grant made at the end of it.
        tbl[0]  = '{4'b1111,  0, 4'b1111, -1,    0};
        tbl[1]  = '{4'b1111,  1, 4'b0001,  0,    0};
        tbl[2]  = '{4'b1111,  2, 4'b0010,  1, 1000};
        tbl[3]  = '{4'b1111,  3, 4'b0100,  2, 2000};
        tbl[4]  = '{4'b1111,  4, 4'b1000,  3, 3000};
        tbl[5]  = '{4'b1111,  5, 4'b0001,  0,    1};
        tbl[6]  = '{4'b1111,  6, 4'b0010,  1, 1002};
        tbl[7]  = '{4'b1111,  7, 4'b0100,  2, 2003};
        tbl[8]  = '{4'b1111,  8, 4'b1000,  3, 3004};
        tbl[9]  = '{4'b0000,  9, 4'b0001,  0,    5};
        tbl[10] = '{4'b0000, 10, 4'b0011,  1, 1006};
        tbl[11] = '{4'b0000, 11, 4'b0111,  2, 2007};
        tbl[12] = '{4'b0000, 12, 4'b1111,  3, 3008};
        tbl[13] = '{4'b0000, 13, 4'b1111, -1,    0};
        tbl[14] = '{4'b0001, 10, 4'b1111, -1,    0};
        tbl[15] = '{4'b0001, 11, 4'b1111,  0,   10};
        tbl[16] = '{4'b0001, 12, 4'b1111,  0,   11};
        tbl[17] = '{4'b0001, 13, 4'b1111,  0,   12};
        tbl[18] = '{4'b0001, 14, 4'b1111,  0,   13};
        tbl[19] = '{4'b0000,  0, 4'b1111,  0,   14};
        tbl[20] = '{4'b0000,  0, 4'b1111, -1,    0};

        rst_in   = 1'b1;
        flush_in = 1'b0;
        drive_all(4'b0000, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;

        chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ix", 32'(cdb_ix), 32'd0);
        chk("rst_value", cdb_value, 32'd0);
        chk("rst_dest", cdb_dest, 32'd0);
        chk("rst_ready", 32'(ready), 32'hF);

        // Single requester: captured end of cycle 1, on the bus in cycle 3 only.
        vld     = 4'b0100;
        rix[2]  = 3'd5;
        rval[2] = -32'sd7;
        rdst[2] = 32'h100;
        begin
            beat_t b;
            b.grant = 4'b0100;
            b.msg   = '{rob_ix: 3'd5, value: -32'sd7, dest: 32'sh100};
            exp_q.push_back(b);
        end
        tick();
        vld = 4'b0000;
        tick();
        chk("single_valid_c3", 32'(cdb_valid), 32'd1);
        chk("single_grant_c3", 32'(grant), 32'b0100);
        tick();
        chk("single_valid_c4", 32'(cdb_valid), 32'd0);

        // Fresh pointer for the contention rows.
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;

        for (int r = 0; r < 21; r++) begin
            drive_all(tbl[r].vld, tbl[r].val);
            #1;
            chk($sformatf("ready_row%0d", r), 32'(ready), 32'(tbl[r].rdy));
            if (tbl[r].src >= 0) push_beat(tbl[r].src, tbl[r].bval);
            tick();
        end

        // Pointer resume: after requester 1 wins, 3 goes before 0.
        drive_all(4'b0010, 77);
        push_beat(1, 1077);
        tick();
        drive_all(4'b0000, 0);
        tick();
        drive_all(4'b1001, 50);
        push_beat(3, 3050);
        push_beat(0, 50);
        tick();
        drive_all(4'b0000, 0);
        tick();
        chk("resume_grant_first", 32'(grant), 32'b1000);
        tick();
        chk("resume_grant_second", 32'(grant), 32'b0001);
        repeat (3) tick();

        // Flush with slots 1 and 2 full and requester 3 presenting.
        drive_all(4'b0110, 20);
        tick();
        drive_all(4'b1000, 23);
        flush_in = 1'b1;
        #1;
        chk("flush_ready_low", 32'(ready), 32'd0);
        tick();
        flush_in = 1'b0;
        drive_all(4'b0000, 0);
        #1;
        chk("flush_valid_after", 32'(cdb_valid), 32'd0);
        chk("flush_ready_after", 32'(ready), 32'hF);
        repeat (4) tick();

        // Reset mid-operation drops held results without a beat.
        drive_all(4'b0110, 30);
        tick();
        drive_all(4'b0000, 0);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        #1;
        chk("midrst_valid", 32'(cdb_valid), 32'd0);
        chk("midrst_ready", 32'(ready), 32'hF);
        repeat (4) tick();

        begin
            int w = 0;
            while (exp_q.size() != 0 && w < 20) begin
                tick();
                w++;
            end
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
        end

`ifdef CDB_ARB_STATS_EN
        mon_en = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int r = 0; r < 9; r++) begin
            drive_all(4'b1111, r);
            tick();
        end
        drive_all(4'b0000, 0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stats_grant%0d", i), gcnt[i], 32'd2);
        chk("stats_conflict_ge6", 32'(ccnt >= 32'd6), 32'd1);
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++)
            chk($sformatf("stats_rst_grant%0d", i), gcnt[i], 32'd0);
        chk("stats_rst_conflict", ccnt, 32'd0);
        tick();
        chk("stats_rst_no_beat", 32'(cdb_valid), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
